// File: rtl/epwm_pkg.sv
// Shared definitions for the ePWM time-base/compare slice: state encoding,
// count-mode constants and default widths.
package epwm_pkg;

  localparam int N_DEF   = 8;
  localparam int DBW_DEF = 4;

  localparam logic MODE_UP     = 1'b0;
  localparam logic MODE_UPDOWN = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

endpackage

// File: rtl/epwm_deadband.sv
// Rising-edge delay: the output follows a falling input at once, but only
// rises after the input has been high for `delay` clk cycles.
module epwm_deadband
  import epwm_pkg::*;
#(
  parameter int DBW = DBW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           raw,
  input  logic [DBW-1:0] delay,
  output logic           out
);

  logic [DBW-1:0] run_cnt;

  // run_cnt is 0 on the first high cycle, saturating so long delays still assert
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt <= '0;
    end else if (!raw) begin
      run_cnt <= '0;
    end else if (run_cnt != '1) begin
      run_cnt <= run_cnt + DBW'(1);
    end
  end

  assign out = raw && (run_cnt >= delay);

endmodule

// File: rtl/epwm_timebase_cmp.sv
// ePWM time-base counter (up / up-down) with shadowed period and compare values,
// registered PWM A/B and zero/period events. Optional macro: EPWM_DEADBAND_EN.
module epwm_timebase_cmp
  import epwm_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int DBW = DBW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           tick,
  input  logic           enable,
  input  logic           cfg_wr,
  input  logic           mode,
  input  logic [N-1:0]   period,
  input  logic [N-1:0]   cmp_a,
  input  logic [N-1:0]   cmp_b,
  input  logic [DBW-1:0] db_cycles,
  output logic [N-1:0]   cnt,
  output logic           pwm_a,
  output logic           pwm_b,
  output logic           zero_evt,
  output logic           period_evt,
  output logic           cfg_pending
);

  state_t       state, state_nxt;
  logic [N-1:0] cnt_nxt;
  logic         mode_sh, mode_act;
  logic [N-1:0] period_sh, period_act;
  logic [N-1:0] cmp_a_sh, cmp_a_act, cmp_b_sh, cmp_b_act;
  logic [N-1:0] cmp_a_use, cmp_b_use;
  logic         load_zero, xfer;
  logic         raw_a, raw_b, raw_a_nxt, raw_b_nxt;

  // Next count and direction, evaluated with the currently active period/mode
  always_comb begin
    cnt_nxt   = cnt;
    state_nxt = state;
    unique case (state)
      UP: begin
        if (cnt >= period_act) begin
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + N'(1);
          if (mode_act == MODE_UPDOWN && cnt_nxt == period_act) state_nxt = DOWN;
        end
      end
      DOWN: begin
        if (cnt <= N'(1)) begin
          cnt_nxt   = '0;
          state_nxt = UP;
        end else begin
          cnt_nxt = cnt - N'(1);
        end
      end
      default: ;
    endcase
  end

  assign load_zero = (cnt_nxt == '0);
  assign xfer      = cfg_pending && ((state == IDLE) || (enable && tick && load_zero));

  // A transfer on this tick already governs the compare of the count it loads
  assign cmp_a_use = xfer ? cmp_a_sh : cmp_a_act;
  assign cmp_b_use = xfer ? cmp_b_sh : cmp_b_act;
  assign raw_a_nxt = (cnt_nxt < cmp_a_use);
`ifdef EPWM_DEADBAND_EN
  assign raw_b_nxt = !raw_a_nxt;
`else
  assign raw_b_nxt = (cnt_nxt < cmp_b_use);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      raw_a       <= 1'b0;
      raw_b       <= 1'b0;
      zero_evt    <= 1'b0;
      period_evt  <= 1'b0;
      cfg_pending <= 1'b0;
      mode_sh     <= MODE_UP;
      period_sh   <= '0;
      cmp_a_sh    <= '0;
      cmp_b_sh    <= '0;
      mode_act    <= MODE_UP;
      period_act  <= '0;
      cmp_a_act   <= '0;
      cmp_b_act   <= '0;
    end else begin
      if (cfg_wr) begin
        mode_sh   <= mode;
        period_sh <= period;
        cmp_a_sh  <= cmp_a;
        cmp_b_sh  <= cmp_b;
      end
      // A write landing on a transfer cycle stays pending for the next one
      if (cfg_wr) begin
        cfg_pending <= 1'b1;
      end else if (xfer) begin
        cfg_pending <= 1'b0;
      end
      if (xfer) begin
        mode_act   <= mode_sh;
        period_act <= period_sh;
        cmp_a_act  <= cmp_a_sh;
        cmp_b_act  <= cmp_b_sh;
      end

      zero_evt   <= 1'b0;
      period_evt <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt   <= '0;
        raw_a <= 1'b0;
        raw_b <= 1'b0;
      end else if (state == IDLE) begin
        state <= UP;
      end else if (tick) begin
        state      <= state_nxt;
        cnt        <= cnt_nxt;
        raw_a      <= raw_a_nxt;
        raw_b      <= raw_b_nxt;
        zero_evt   <= load_zero;
        period_evt <= !load_zero && (cnt_nxt == period_act);
      end
    end
  end

`ifdef EPWM_DEADBAND_EN
  logic [DBW-1:0] db_sh, db_act;
  logic           unused_cmp_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_sh  <= '0;
      db_act <= '0;
    end else begin
      if (cfg_wr) db_sh <= db_cycles;
      if (xfer) db_act <= db_sh;
    end
  end

  epwm_deadband #(.DBW(DBW)) u_db_a (
    .clk   (clk),
    .reset (reset),
    .raw   (raw_a),
    .delay (db_act),
    .out   (pwm_a)
  );

  epwm_deadband #(.DBW(DBW)) u_db_b (
    .clk   (clk),
    .reset (reset),
    .raw   (raw_b),
    .delay (db_act),
    .out   (pwm_b)
  );

  assign unused_cmp_b = ^cmp_b_use;
`else
  logic unused_db;

  assign pwm_a     = raw_a;
  assign pwm_b     = raw_b;
  assign unused_db = ^db_cycles;
`endif

endmodule

// File: tb/tb_epwm_timebase_cmp.sv
// Directed bench for epwm_timebase_cmp: expected outputs are queued with each
// stimulus step and compared one clock later, after the active edge.
module tb_epwm_timebase_cmp;

  typedef struct packed {
    logic [7:0] cnt;
    logic       a;
    logic       b;
    logic       z;
    logic       p;
    logic       pend;
  } exp_t;

  logic       clk, reset, tick, enable, cfg_wr, mode;
  logic [7:0] period, cmp_a, cmp_b;
  logic [3:0] db_cycles;
  logic [7:0] cnt;
  logic       pwm_a, pwm_b, zero_evt, period_evt, cfg_pending;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  epwm_timebase_cmp #(.N(8), .DBW(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .enable      (enable),
    .cfg_wr      (cfg_wr),
    .mode        (mode),
    .period      (period),
    .cmp_a       (cmp_a),
    .cmp_b       (cmp_b),
    .db_cycles   (db_cycles),
    .cnt         (cnt),
    .pwm_a       (pwm_a),
    .pwm_b       (pwm_b),
    .zero_evt    (zero_evt),
    .period_evt  (period_evt),
    .cfg_pending (cfg_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ex(input int c, input int a, input int b,
                              input int z, input int p, input int pend);
    exp_t e;
    e.cnt  = 8'(c);
    e.a    = (a != 0);
    e.b    = (b != 0);
    e.z    = (z != 0);
    e.p    = (p != 0);
    e.pend = (pend != 0);
    return e;
  endfunction

  task automatic cmp(input string tag, input string fld, input logic [7:0] obs,
                     input logic [7:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s.%s observed=%0d expected=%0d", tag, fld, obs, expv);
  endtask

  task automatic check_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
      return;
    end
    e = sb.pop_front();
    cmp(tag, "cnt", cnt, e.cnt);
    cmp(tag, "pwm_a", {7'b0, pwm_a}, {7'b0, e.a});
    cmp(tag, "pwm_b", {7'b0, pwm_b}, {7'b0, e.b});
    cmp(tag, "zero_evt", {7'b0, zero_evt}, {7'b0, e.z});
    cmp(tag, "period_evt", {7'b0, period_evt}, {7'b0, e.p});
    cmp(tag, "cfg_pending", {7'b0, cfg_pending}, {7'b0, e.pend});
  endtask

  task automatic step(input string tag, input logic t, input exp_t e);
    tick = t;
    sb.push_back(e);
    @(posedge clk);
    #1;
    tick   = 1'b0;
    cfg_wr = 1'b0;
    check_front(tag);
  endtask

  task automatic reconfigure(input logic m, input int p, input int a, input int b,
                             input int db);
    enable = 1'b0;
    step("cfg_idle", 1'b0, ex(0, 0, 0, 0, 0, 0));
    mode      = m;
    period    = 8'(p);
    cmp_a     = 8'(a);
    cmp_b     = 8'(b);
    db_cycles = 4'(db);
    cfg_wr    = 1'b1;
    step("cfg_wr", 1'b0, ex(0, 0, 0, 0, 0, 1));
    step("cfg_xfer", 1'b0, ex(0, 0, 0, 0, 0, 0));
    enable = 1'b1;
    step("cfg_run", 1'b0, ex(0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0; enable = 1'b0; cfg_wr = 1'b0; mode = 1'b0;
    period = '0; cmp_a = '0; cmp_b = '0; db_cycles = '0;
    #2;
    sb.push_back(ex(0, 0, 0, 0, 0, 0));
    check_front("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

`ifdef EPWM_DEADBAND_EN
    begin
      int  k = 0;
      int  run_a = 0;
      int  run_b = 0;
      int  c;
      bit  ra, rb, oa, ob;
      reconfigure(1'b0, 9, 5, 0, 2);
      for (int i = 0; i < 25; i++) begin
        k++;
        c  = k % 10;
        ra = (c < 5);
        rb = !ra;
        oa = ra && (run_a >= 2);
        ob = rb && (run_b >= 2);
        run_a = ra ? run_a + 1 : 0;
        run_b = rb ? run_b + 1 : 0;
        step("deadband", 1'b1, ex(c, oa, ob, c == 0, c == 9, 0));
        cmp("deadband", "overlap", {7'b0, pwm_a & pwm_b}, 8'd0);
      end
    end
`else
    // up-count, period 4
    reconfigure(1'b0, 4, 2, 3, 0);
    step("up", 1'b1, ex(1, 1, 1, 0, 0, 0));
    step("up", 1'b1, ex(2, 0, 1, 0, 0, 0));
    step("up", 1'b1, ex(3, 0, 0, 0, 0, 0));
    step("up", 1'b1, ex(4, 0, 0, 0, 1, 0));
    step("up", 1'b1, ex(0, 1, 1, 1, 0, 0));
    step("up", 1'b1, ex(1, 1, 1, 0, 0, 0));
    step("up", 1'b1, ex(2, 0, 1, 0, 0, 0));

    // enable abort at cnt=2, then restart from 0
    enable = 1'b0;
    step("abort", 1'b1, ex(0, 0, 0, 0, 0, 0));
    step("idle_hold", 1'b1, ex(0, 0, 0, 0, 0, 0));
    enable = 1'b1;
    step("reenter", 1'b0, ex(0, 0, 0, 0, 0, 0));
    step("restart", 1'b1, ex(1, 1, 1, 0, 0, 0));

    // shadowing: write mid-period, then a write coinciding with the transfer
    reconfigure(1'b0, 4, 3, 3, 0);
    step("shw", 1'b1, ex(1, 1, 1, 0, 0, 0));
    step("shw", 1'b1, ex(2, 1, 1, 0, 0, 0));
    cmp_a = 8'd1; cfg_wr = 1'b1;
    step("shw_wr", 1'b0, ex(2, 1, 1, 0, 0, 1));
    step("shw_old", 1'b1, ex(3, 0, 0, 0, 0, 1));
    step("shw_old", 1'b1, ex(4, 0, 0, 0, 1, 1));
    cmp_a = 8'd4; cfg_wr = 1'b1;
    step("shw_coinc", 1'b1, ex(0, 1, 1, 1, 0, 1));
    step("shw_new1", 1'b1, ex(1, 0, 1, 0, 0, 1));
    step("shw_new1", 1'b1, ex(2, 0, 1, 0, 0, 1));
    step("shw_new1", 1'b1, ex(3, 0, 0, 0, 0, 1));
    step("shw_new1", 1'b1, ex(4, 0, 0, 0, 1, 1));
    step("shw_xfer2", 1'b1, ex(0, 1, 1, 1, 0, 0));
    step("shw_new4", 1'b1, ex(1, 1, 1, 0, 0, 0));

    // tick every 3rd clk; cmp_a=0 never high, cmp_b above period always high
    reconfigure(1'b0, 4, 0, 5, 0);
    begin
      int k = 0;
      int c;
      bit t;
      for (int i = 0; i < 18; i++) begin
        t = (i % 3 == 0);
        if (t) k++;
        c = k % 5;
        step("presc", t, ex(c, 0, k > 0, t && c == 0, t && c == 4, 0));
      end
    end

    // period 0 in both modes: zero_evt every tick, period_evt never
    for (int m = 0; m < 2; m++) begin
      reconfigure(m[0], 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) step("per0", 1'b1, ex(0, 1, 0, 1, 0, 0));
    end

    // up-down, period 3
    reconfigure(1'b1, 3, 2, 1, 0);
    step("updn", 1'b1, ex(1, 1, 0, 0, 0, 0));
    step("updn", 1'b1, ex(2, 0, 0, 0, 0, 0));
    step("updn", 1'b1, ex(3, 0, 0, 0, 1, 0));
    step("updn", 1'b1, ex(2, 0, 0, 0, 0, 0));
    step("updn", 1'b1, ex(1, 1, 0, 0, 0, 0));
    step("updn", 1'b1, ex(0, 1, 1, 1, 0, 0));
    step("updn", 1'b1, ex(1, 1, 0, 0, 0, 0));
    step("updn", 1'b1, ex(2, 0, 0, 0, 0, 0));
    step("updn", 1'b1, ex(3, 0, 0, 0, 1, 0));

    // asynchronous reset at cnt=3, observed before the next clock edge
    reset = 1'b1;
    #2;
    sb.push_back(ex(0, 0, 0, 0, 0, 0));
    check_front("async_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    step("post_reset", 1'b1, ex(0, 0, 0, 0, 0, 0));
    step("post_reset", 1'b1, ex(0, 0, 0, 1, 0, 0));
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
